// File: rtl/nes_cpu_pkg.sv
// Shared CPU definitions: address width, fetch FSM states and 6502-style
// instruction length decode.
package nes_cpu_pkg;

    localparam int unsigned MEM_ADDR_SIZE = 8;

    typedef enum logic [0:0] {
        StVec,
        StRun
    } fetch_state_e;

    typedef logic [1:0] len_t;

    // Length from opcode groups: cc = opcode[1:0], bbb = opcode[4:2].
    function automatic len_t len_decode(input logic [7:0] opcode);
        logic [1:0] cc;
        logic [2:0] bbb;
        len_t       len;
        cc  = opcode[1:0];
        bbb = opcode[4:2];
        len = 2'd1;
        case (cc)
            2'b01: begin
                if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) begin
                    len = 2'd3;
                end else begin
                    len = 2'd2;
                end
            end
            2'b00, 2'b10: begin
                if (opcode == 8'h00 || opcode == 8'h40 || opcode == 8'h60) begin
                    len = 2'd1;
                end else if (opcode == 8'h20) begin
                    len = 2'd3;
                end else begin
                    case (bbb)
                        3'b000, 3'b001, 3'b101: len = 2'd2;
                        3'b011, 3'b111:         len = 2'd3;
                        3'b100:                 len = (cc == 2'b00) ? 2'd2 : 2'd1;
                        default:                len = 2'd1;
                    endcase
                end
            end
            default: len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational opcode-to-length decoder.
module instr_len_decode
    import nes_cpu_pkg::*;
(
    input  logic [7:0] opcode_i,
    output len_t       len_o
);

    assign len_o = len_decode(opcode_i);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: loads the reset vector, then streams variable-length
// instructions from a combinational 3-byte-read memory into a decode register.
module fetch_unit
    import nes_cpu_pkg::*;
#(
    parameter logic [MEM_ADDR_SIZE-1:0] VECTOR_ADDR = MEM_ADDR_SIZE'((2 ** MEM_ADDR_SIZE) - 4)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
    input  logic [23:0]              mem_data_i,
    input  logic                     redirect_valid_i,
    input  logic [MEM_ADDR_SIZE-1:0] redirect_pc_i,
    output logic                     dec_valid_o,
    input  logic                     dec_ready_i,
    output logic [23:0]              dec_instr_o,
    output logic [1:0]               dec_len_o,
    output logic [MEM_ADDR_SIZE-1:0] dec_pc_o
);

    fetch_state_e             state_q, state_d;
    logic [MEM_ADDR_SIZE-1:0] pc_q, pc_d;
    logic                     valid_q, valid_d;
    logic [23:0]              instr_q, instr_d;
    len_t                     len_q, len_d;
    logic [MEM_ADDR_SIZE-1:0] dpc_q, dpc_d;
    len_t                     cur_len;
    logic                     out_free;

    instr_len_decode u_len_decode (
        .opcode_i (mem_data_i[7:0]),
        .len_o    (cur_len)
    );

    assign out_free   = !valid_q || dec_ready_i;
    assign mem_addr_o = (state_q == StVec) ? VECTOR_ADDR : pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        len_d   = len_q;
        dpc_d   = dpc_q;
        // Redirect wins over vector load and capture; the held instruction is dropped.
        if (redirect_valid_i) begin
            state_d = StRun;
            pc_d    = redirect_pc_i;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                StVec: begin
                    pc_d    = mem_data_i[MEM_ADDR_SIZE-1:0];
                    state_d = StRun;
                end
                StRun: begin
                    if (out_free) begin
                        instr_d = mem_data_i;
                        len_d   = cur_len;
                        dpc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + MEM_ADDR_SIZE'(cur_len);
                    end
                end
                default: state_d = StVec;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StVec;
            pc_q    <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            len_q   <= 2'd1;
            dpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            len_q   <= len_d;
            dpc_q   <= dpc_d;
        end
    end

    assign dec_valid_o = valid_q;
    assign dec_instr_o = instr_q;
    assign dec_len_o   = len_q;
    assign dec_pc_o    = dpc_q;

endmodule
